// File: rtl/ram_arb_pkg.sv
// Shared types for the IFU/LSU RAM arbiter.
// Size codes match the LSU's encoding.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ERR   = 2'd3
  } state_e;

  localparam logic [1:0] HB_BYTE = 2'b00;
  localparam logic [1:0] HB_HALF = 2'b01;
  localparam logic [1:0] HB_WORD = 2'b10;

  localparam logic REQ_IFU = 1'b0;
  localparam logic REQ_LSU = 1'b1;

  typedef struct packed {
    logic        we;
    logic [1:0]  hb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cmd_t;

endpackage

// File: rtl/ram_arb_rr.sv
// Two-way round-robin picker; bit index is the requester ID.
// Grants only while adv_i is high.
module ram_arb_rr
  import ram_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       ptr_i,
  input  logic       adv_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    if (adv_i) begin
      unique case (1'b1)
        (req_i == 2'b11): gnt_o = ptr_i ? 2'b10 : 2'b01;
        (req_i == 2'b01): gnt_o = 2'b01;
        (req_i == 2'b10): gnt_o = 2'b10;
        default:          gnt_o = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares a single-ported RAM between IFU and LSU with round-robin
// fairness; bad accesses are answered locally with an error.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter logic [31:0] RAM_BASE  = 32'h0000_0000,
  parameter int unsigned RAM_BYTES = 16384
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ifu_req_i,
  input  logic [31:0] ifu_addr_i,
  output logic        ifu_gnt_o,
  output logic [31:0] ifu_rdata_o,
  output logic        ifu_err_o,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [1:0]  lsu_hb_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_wdata_i,
  output logic        lsu_gnt_o,
  output logic [31:0] lsu_rdata_o,
  output logic        lsu_err_o,
  output logic        mem_ce_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [1:0]  mem_hb_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic [31:0] mem_rdata_i
);

  state_e      state_q, state_d;
  logic        owner_q, owner_d;
  logic        ptr_q, ptr_d;
  cmd_t        cmd_q, cmd_d;

  logic [1:0]  win;
  logic        sel_we;
  logic [1:0]  sel_hb;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [32:0] sel_off;
  logic        sel_bad;
  logic        done;
  logic        gnt;
  logic [31:0] rdata;

  ram_arb_rr u_rr (
    .req_i ({lsu_req_i, ifu_req_i}),
    .ptr_i (ptr_q),
    .adv_i (state_q == IDLE),
    .gnt_o (win)
  );

  // Fetches are always word reads.
  always_comb begin
    sel_we    = 1'b0;
    sel_hb    = HB_WORD;
    sel_addr  = ifu_addr_i;
    sel_wdata = '0;
    if (win[REQ_LSU]) begin
      sel_we    = lsu_we_i;
      sel_hb    = lsu_hb_i;
      sel_addr  = lsu_addr_i;
      sel_wdata = lsu_wdata_i;
    end
  end

  // Borrow out of the 33-bit subtract flags addr below the base.
  always_comb begin
    sel_off = {1'b0, sel_addr} - {1'b0, RAM_BASE};
    sel_bad = (sel_hb == 2'b11)
            | ((sel_hb == HB_WORD) & (sel_addr[1:0] != 2'b00))
            | ((sel_hb == HB_HALF) & sel_addr[0])
            | sel_off[32]
            | (sel_off[31:0] >= RAM_BYTES);
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cmd_d   = cmd_q;
    unique case (state_q)
      IDLE: begin
        if (|win) begin
          owner_d = win[REQ_LSU] ? REQ_LSU : REQ_IFU;
          cmd_d   = '{we: sel_we, hb: sel_hb,
                      addr: sel_off[31:0], wdata: sel_wdata};
          state_d = sel_bad ? ERR : ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (mem_gnt_i) begin
          state_d = IDLE;
          ptr_d   = ~owner_q;
        end
      end
      ERR: begin
        state_d = IDLE;
        ptr_d   = ~owner_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      owner_q <= REQ_IFU;
      ptr_q   <= REQ_LSU;
      cmd_q   <= '{we: 1'b0, hb: HB_WORD, addr: '0, wdata: '0};
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cmd_q   <= cmd_d;
    end
  end

  // A RAM grant arriving in the reset cycle belongs to an abandoned access.
  always_comb begin
    done  = ((state_q == WAIT) & mem_gnt_i) | (state_q == ERR);
    gnt   = done & ~rst_i;
    rdata = '0;
    if (gnt & (state_q == WAIT) & ~cmd_q.we) rdata = mem_rdata_i;
  end

  assign ifu_gnt_o   = gnt & (owner_q == REQ_IFU);
  assign lsu_gnt_o   = gnt & (owner_q == REQ_LSU);
  assign ifu_err_o   = ifu_gnt_o & (state_q == ERR);
  assign lsu_err_o   = lsu_gnt_o & (state_q == ERR);
  assign ifu_rdata_o = ifu_gnt_o ? rdata : '0;
  assign lsu_rdata_o = lsu_gnt_o ? rdata : '0;

  assign mem_req_o   = (state_q == ISSUE);
  assign mem_ce_o    = (state_q == ISSUE) | (state_q == WAIT);
  assign mem_we_o    = cmd_q.we;
  assign mem_hb_o    = cmd_q.hb;
  assign mem_addr_o  = cmd_q.addr;
  assign mem_wdata_o = cmd_q.wdata;

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: behavioural RAM, reference
// memory image and a spec-level round-robin order check.
module tb_ram_arbiter;
  import ram_arb_pkg::*;

  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int          BYTES = 16384;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        ifu_req_i;
  logic [31:0] ifu_addr_i;
  logic        ifu_gnt_o;
  logic [31:0] ifu_rdata_o;
  logic        ifu_err_o;
  logic        lsu_req_i;
  logic        lsu_we_i;
  logic [1:0]  lsu_hb_i;
  logic [31:0] lsu_addr_i;
  logic [31:0] lsu_wdata_i;
  logic        lsu_gnt_o;
  logic [31:0] lsu_rdata_o;
  logic        lsu_err_o;
  logic        mem_ce_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [1:0]  mem_hb_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i;
  logic [31:0] mem_rdata_i;

  ram_arbiter #(.RAM_BASE(BASE), .RAM_BYTES(BYTES)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ifu_req_i(ifu_req_i), .ifu_addr_i(ifu_addr_i),
    .ifu_gnt_o(ifu_gnt_o), .ifu_rdata_o(ifu_rdata_o),
    .ifu_err_o(ifu_err_o),
    .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_hb_i(lsu_hb_i),
    .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i),
    .lsu_gnt_o(lsu_gnt_o), .lsu_rdata_o(lsu_rdata_o),
    .lsu_err_o(lsu_err_o),
    .mem_ce_o(mem_ce_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_hb_o(mem_hb_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int req_cnt = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Behavioural RAM: grant one cycle after req&ce, combinational read.
  logic [7:0] ram [BYTES];
  logic [7:0] ref_mem [BYTES];

  function automatic logic [7:0] init_byte(input int i);
    logic [31:0] v;
    v = 32'hDEADBEEF;
    if (i >= 16 && i < 20) return v[8*(i-16) +: 8];
    return 8'(i * 7 + 3);
  endfunction

  initial begin
    int wa;
    for (int i = 0; i < BYTES; i++) ram[i] = init_byte(i);
    mem_gnt_i = 1'b0;
    forever begin
      @(posedge clk_i);
      if (rst_i) mem_gnt_i <= 1'b0;
      else begin
        mem_gnt_i <= mem_req_o & mem_ce_o;
        if (mem_req_o & mem_ce_o & mem_we_o) begin
          wa = int'(mem_addr_o[13:0]);
          ram[wa] <= mem_wdata_o[7:0];
          if (mem_hb_o != HB_BYTE) ram[(wa+1)%BYTES] <= mem_wdata_o[15:8];
          if (mem_hb_o == HB_WORD) begin
            ram[(wa+2)%BYTES] <= mem_wdata_o[23:16];
            ram[(wa+3)%BYTES] <= mem_wdata_o[31:24];
          end
        end
      end
    end
  end

  int ra;
  always_comb begin
    ra = int'(mem_addr_o[13:0]);
    case (mem_hb_o)
      HB_BYTE: mem_rdata_i = {{24{ram[ra][7]}}, ram[ra]};
      HB_HALF: mem_rdata_i = {{16{ram[(ra+1)%BYTES][7]}},
                              ram[(ra+1)%BYTES], ram[ra]};
      default: mem_rdata_i = {ram[(ra+3)%BYTES], ram[(ra+2)%BYTES],
                              ram[(ra+1)%BYTES], ram[ra]};
    endcase
  end

  // Reference model of the access rules and memory contents.
  function automatic bit valid_acc(input bit [1:0] hb, input bit [31:0] a);
    longint la;
    la = longint'(a);
    if (hb == 2'b11) return 1'b0;
    if (hb == HB_WORD && a[1:0] != 2'b00) return 1'b0;
    if (hb == HB_HALF && a[0]) return 1'b0;
    return (la >= longint'(BASE)) && (la < longint'(BASE) + BYTES);
  endfunction

  function automatic bit [31:0] ref_load(input bit [1:0] hb, input bit [31:0] a);
    int o;
    bit [31:0] w;
    o = int'(a - BASE);
    w = {ref_mem[(o+3)%BYTES], ref_mem[(o+2)%BYTES],
         ref_mem[(o+1)%BYTES], ref_mem[o]};
    if (hb == HB_BYTE) return 32'($signed(w[7:0]));
    if (hb == HB_HALF) return 32'($signed(w[15:0]));
    return w;
  endfunction

  task automatic ref_store(input bit [1:0] hb, input bit [31:0] a, input bit [31:0] d);
    int o;
    int n;
    o = int'(a - BASE);
    n = (hb == HB_BYTE) ? 1 : (hb == HB_HALF) ? 2 : 4;
    for (int k = 0; k < n; k++) ref_mem[o+k] = d[8*k +: 8];
  endtask

  typedef struct { bit [31:0] rdata; bit err; } exp_t;
  exp_t ifu_q[$];
  exp_t lsu_q[$];

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", n, act, exp);
    end
  endtask

  // Monitor: scoreboard pop plus round-robin winner prediction.
  bit ifu_h[int];
  bit lsu_h[int];
  bit last_srv = REQ_IFU;

  task automatic handle(input bit port, input logic [31:0] rd, input logic er);
    exp_t e;
    int s;
    bit both;
    bit exp_w;
    if ((port == REQ_LSU ? lsu_q.size() : ifu_q.size()) == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_gnt port=%0d actual=gnt required=none", port);
      return;
    end
    if (port == REQ_LSU) e = lsu_q.pop_front();
    else e = ifu_q.pop_front();
    chk(port == REQ_LSU ? "lsu_rdata" : "ifu_rdata", rd, e.rdata);
    chk(port == REQ_LSU ? "lsu_err" : "ifu_err", 32'(er), 32'(e.err));
    s = cyc - (e.err ? 1 : 2);
    both = ifu_h.exists(s) && lsu_h.exists(s) && ifu_h[s] && lsu_h[s];
    if (both) exp_w = ~last_srv;
    else exp_w = (lsu_h.exists(s) && lsu_h[s]) ? REQ_LSU : REQ_IFU;
    chk("winner", 32'(port), 32'(exp_w));
    last_srv = port;
  endtask

  initial begin
    forever begin
      @(negedge clk_i);
      ifu_h[cyc] = ifu_req_i;
      lsu_h[cyc] = lsu_req_i;
      if (rst_i) last_srv = REQ_IFU;
      if (mem_req_o === 1'b1) req_cnt++;
      if (ifu_gnt_o === 1'b1) handle(REQ_IFU, ifu_rdata_o, ifu_err_o);
      else chk("ifu_rdata_idle", ifu_rdata_o, 32'h0);
      if (lsu_gnt_o === 1'b1) handle(REQ_LSU, lsu_rdata_o, lsu_err_o);
      else chk("lsu_rdata_idle", lsu_rdata_o, 32'h0);
    end
  end

  // One request from issue to gnt; lat counts cycles after the sample cycle.
  task automatic txn(input bit port, input bit we, input bit [1:0] hb,
                     input bit [31:0] a, input bit [31:0] wd,
                     output bit [31:0] rd, output bit er, output int lat);
    exp_t e;
    bit ok;
    bit got;
    if (port == REQ_IFU) begin
      we = 1'b0;
      hb = HB_WORD;
      wd = '0;
    end
    ok = valid_acc(hb, a);
    e.err = ~ok;
    e.rdata = (!ok || we) ? 32'h0 : ref_load(hb, a);
    if (ok && we) ref_store(hb, a, wd);
    if (port == REQ_LSU) begin
      lsu_q.push_back(e);
      lsu_we_i = we; lsu_hb_i = hb; lsu_addr_i = a; lsu_wdata_i = wd;
      lsu_req_i = 1'b1;
    end else begin
      ifu_q.push_back(e);
      ifu_addr_i = a;
      ifu_req_i = 1'b1;
    end
    lat = 0; rd = '0; er = 1'b0; got = 1'b0;
    while (!got && lat < 60) begin
      @(negedge clk_i);
      if (port == REQ_LSU && lsu_gnt_o === 1'b1) begin
        got = 1'b1; rd = lsu_rdata_o; er = lsu_err_o;
      end else if (port == REQ_IFU && ifu_gnt_o === 1'b1) begin
        got = 1'b1; rd = ifu_rdata_o; er = ifu_err_o;
      end else lat++;
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL gnt_timeout port=%0d actual=none required=gnt", port);
      if (port == REQ_LSU && lsu_q.size() > 0) void'(lsu_q.pop_back());
      if (port == REQ_IFU && ifu_q.size() > 0) void'(ifu_q.pop_back());
    end
    @(posedge clk_i);
    #1;
    if (port == REQ_LSU) lsu_req_i = 1'b0;
    else ifu_req_i = 1'b0;
  endtask

  task automatic chk_reset_outs(input string n);
    chk({n, "_mem_req"}, 32'(mem_req_o), 32'h0);
    chk({n, "_mem_ce"}, 32'(mem_ce_o), 32'h0);
    chk({n, "_mem_we"}, 32'(mem_we_o), 32'h0);
    chk({n, "_mem_hb"}, 32'(mem_hb_o), 32'h2);
    chk({n, "_mem_addr"}, mem_addr_o, 32'h0);
    chk({n, "_mem_wdata"}, mem_wdata_o, 32'h0);
    chk({n, "_gnts"}, {28'h0, ifu_gnt_o, ifu_err_o, lsu_gnt_o, lsu_err_o}, 32'h0);
  endtask

  initial begin
    bit [31:0] rd;
    bit er;
    int lat;
    int c0;
    for (int i = 0; i < BYTES; i++) ref_mem[i] = init_byte(i);
    rst_i = 1'b1;
    ifu_req_i = 0; ifu_addr_i = '0;
    lsu_req_i = 0; lsu_we_i = 0; lsu_hb_i = HB_WORD;
    lsu_addr_i = '0; lsu_wdata_i = '0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk_reset_outs("reset");
    @(posedge clk_i);
    #1 rst_i = 1'b0;

    // Single fetch of word 4.
    c0 = req_cnt;
    txn(REQ_IFU, 0, HB_WORD, 32'h10, 0, rd, er, lat);
    chk("fetch_rdata", rd, 32'hDEADBEEF);
    chk("fetch_err", 32'(er), 32'h0);
    chk("fetch_lat", 32'(lat), 32'd2);
    chk("fetch_mem_req", 32'(req_cnt - c0), 32'd1);

    // Two collisions: LSU first each time.
    repeat (2) begin
      fork
        begin
          bit [31:0] r1; bit e1; int l1;
          txn(REQ_LSU, 0, HB_WORD, 32'h2000, 0, r1, e1, l1);
          chk("coll_lsu_lat", 32'(l1), 32'd2);
        end
        begin
          bit [31:0] r2; bit e2; int l2;
          txn(REQ_IFU, 0, HB_WORD, 32'h20, 0, r2, e2, l2);
          chk("coll_ifu_lat", 32'(l2), 32'd5);
        end
      join
    end

    // 20 back-to-back pairs.
    fork
      for (int i = 0; i < 20; i++) begin
        bit [31:0] r1; bit e1; int l1;
        txn(REQ_LSU, 0, HB_WORD, 32'h2000 + 32'(4*i), 0, r1, e1, l1);
      end
      for (int i = 0; i < 20; i++) begin
        bit [31:0] r2; bit e2; int l2;
        txn(REQ_IFU, 0, HB_WORD, 32'h100 + 32'(4*i), 0, r2, e2, l2);
      end
    join

    // Byte store then sign-extended byte load.
    txn(REQ_LSU, 1, HB_BYTE, 32'h103, 32'h80, rd, er, lat);
    chk("store_rdata", rd, 32'h0);
    chk("store_lat", 32'(lat), 32'd2);
    txn(REQ_LSU, 0, HB_BYTE, 32'h103, 0, rd, er, lat);
    chk("load_sext", rd, 32'hFFFF_FF80);

    // Rejected accesses never reach the RAM.
    c0 = req_cnt;
    txn(REQ_LSU, 0, HB_WORD, 32'h102, 0, rd, er, lat);
    chk("mis_word_err", 32'(er), 32'h1);
    chk("mis_word_lat", 32'(lat), 32'd1);
    txn(REQ_LSU, 0, HB_HALF, 32'h001, 0, rd, er, lat);
    chk("mis_half_err", 32'(er), 32'h1);
    chk("mis_half_lat", 32'(lat), 32'd1);
    txn(REQ_LSU, 1, HB_WORD, BASE + 32'(BYTES), 32'h1234, rd, er, lat);
    chk("oor_err", 32'(er), 32'h1);
    chk("oor_lat", 32'(lat), 32'd1);
    txn(REQ_LSU, 0, 2'b11, 32'h2000, 0, rd, er, lat);
    chk("ill_hb_err", 32'(er), 32'h1);
    chk("err_no_mem_req", 32'(req_cnt - c0), 32'd0);

    // Reset during WAIT of a load.
    lsu_we_i = 0; lsu_hb_i = HB_WORD; lsu_addr_i = 32'h2004;
    lsu_req_i = 1'b1;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    chk("pre_rst_in_wait", 32'(mem_ce_o & ~mem_req_o), 32'h1);
    rst_i = 1'b1;
    lsu_req_i = 1'b0;
    @(negedge clk_i);
    chk("rst_no_gnt", 32'(lsu_gnt_o), 32'h0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    chk_reset_outs("after_rst");
    @(posedge clk_i); #1;
    txn(REQ_LSU, 0, HB_WORD, 32'h2004, 0, rd, er, lat);
    chk("post_rst_lat", 32'(lat), 32'd2);

    // Random concurrent traffic; LSU stores stay above the fetch region.
    fork
      for (int i = 0; i < 40; i++) begin
        bit [31:0] a; bit [31:0] r; bit e; int l;
        a = 32'($urandom_range(0, 32'h1FFF)) & ~32'h3;
        if ($urandom_range(0, 7) == 0) a = a + 32'h1;
        if ($urandom_range(0, 9) == 0) a = 32'h8000_0000;
        txn(REQ_IFU, 0, HB_WORD, a, 0, r, e, l);
        repeat ($urandom_range(0, 2)) begin @(posedge clk_i); #1; end
      end
      for (int i = 0; i < 40; i++) begin
        bit [31:0] a; bit [1:0] hb; bit we; bit [31:0] r; bit e; int l;
        hb = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
        we = 1'($urandom_range(0, 1));
        a = 32'h2000 + 32'($urandom_range(0, 32'h1FFF));
        if ($urandom_range(0, 3) != 0) begin
          if (hb == HB_WORD) a = a & ~32'h3;
          if (hb == HB_HALF) a = a & ~32'h1;
        end
        if ($urandom_range(0, 9) == 0) a = 32'h4000 + 32'($urandom_range(0, 255));
        txn(REQ_LSU, we, hb, a, $urandom, r, e, l);
        repeat ($urandom_range(0, 2)) begin @(posedge clk_i); #1; end
      end
    join

    repeat (4) @(posedge clk_i);
    chk("ifu_q_drained", 32'(ifu_q.size()), 32'h0);
    chk("lsu_q_drained", 32'(lsu_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
